// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception arbiter and flush sequencer
//
// Picks the highest-priority exception for the instruction in MEM. One cycle
// later it reports that exception to CP0 and drives a single-cycle flush with
// a redirect PC. A blackout window follows, so that no exception is taken
// twice and none is attached to a pipeline bubble.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_inst_valid              MEM holds a real instruction (not a bubble)
//   mem_pc, mem_in_delayslot    PC / delay-slot flag of the MEM instruction
//   mem_exc_flags               {eret, ov, trap, inst_invalid, syscall}
//   cp0_status/cause/epc        architectural CP0 values
//   wb_cp0_we/waddr/data        CP0 write in WB, bypassed onto the CP0 values
//   excepttype_o                exception code, valid for one cycle
//   current_inst_addr_o         faulting PC (held after the flush)
//   is_in_delayslot_o           faulting delay-slot flag (held after the flush)
//   flush_o, new_pc_o           pipeline flush and redirect PC
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR    = 32'h0000_0020,
  parameter int          BLACKOUT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_inst_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [4:0]  mem_exc_flags,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_data,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [3:0] BO_LOAD     = 4'(BLACKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TAKE     = 2'd1,
    BLACKOUT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        int_pending, int_pending_n;

  logic [31:0] excepttype_n, addr_n, new_pc_n;
  logic        ds_n, flush_n;

  logic [31:0] eff_status, eff_epc;
  logic [7:0]  eff_ip;
  logic        int_req;
  logic        cand;
  logic [31:0] cand_code;
  logic        unused_bits;

  // WB-stage CP0 writes have not reached the register file yet, so forward them.
  always_comb begin
    eff_status = cp0_status;
    eff_epc    = cp0_epc;
    eff_ip     = cp0_cause[15:8];
    if (wb_cp0_we && wb_cp0_waddr == ADDR_STATUS) eff_status = wb_cp0_data;
    if (wb_cp0_we && wb_cp0_waddr == ADDR_EPC)    eff_epc    = wb_cp0_data;
    // Only the software interrupt bits of Cause are writable.
    if (wb_cp0_we && wb_cp0_waddr == ADDR_CAUSE)  eff_ip[1:0] = wb_cp0_data[9:8];
  end

  assign int_req = (|(eff_ip & eff_status[15:8])) & eff_status[0] & ~eff_status[1];

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  // Priority encoder; candidates exist only for real instructions in IDLE.
  always_comb begin
    cand_code = 32'h0;
    if (state == IDLE && mem_inst_valid) begin
      if (int_req || int_pending)  cand_code = 32'h1;
      else if (mem_exc_flags[0])   cand_code = 32'h8;
      else if (mem_exc_flags[1])   cand_code = 32'hA;
      else if (mem_exc_flags[2])   cand_code = 32'hD;
      else if (mem_exc_flags[3])   cand_code = 32'hC;
      else if (mem_exc_flags[4])   cand_code = 32'hE;
    end
    cand = (cand_code != 32'h0);
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    int_pending_n = int_pending;
    excepttype_n  = 32'h0;
    flush_n       = 1'b0;
    new_pc_n      = 32'h0;
    addr_n        = current_inst_addr_o;
    ds_n          = is_in_delayslot_o;
    case (state)
      IDLE: begin
        cnt_n = 4'd0;
        if (cand) begin
          state_n       = TAKE;
          int_pending_n = 1'b0;
          excepttype_n  = cand_code;
          addr_n        = mem_pc;
          ds_n          = mem_in_delayslot;
          flush_n       = 1'b1;
          new_pc_n      = (cand_code == 32'hE) ? eff_epc : HANDLER_ADDR;
        end else if (!int_req) begin
          int_pending_n = 1'b0;
        end else if (!mem_inst_valid) begin
          // Interrupt arrived on a bubble: remember it for the next real instruction.
          int_pending_n = 1'b1;
        end
      end
      TAKE: begin
        state_n = BLACKOUT;
        cnt_n   = BO_LOAD;
        if (!int_req) int_pending_n = 1'b0;
      end
      BLACKOUT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      int_pending         <= 1'b0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      int_pending         <= int_pending_n;
      excepttype_o        <= excepttype_n;
      current_inst_addr_o <= addr_n;
      is_in_delayslot_o   <= ds_n;
      flush_o             <= flush_n;
      new_pc_o            <= new_pc_n;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_inst_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [4:0]  mem_exc_flags;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_waddr;
  logic [31:0] wb_cp0_data;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int checks   = 0;
  int failures = 0;

  exc_ctrl #(.HANDLER_ADDR(32'h20), .BLACKOUT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .mem_inst_valid(mem_inst_valid), .mem_pc(mem_pc),
    .mem_in_delayslot(mem_in_delayslot), .mem_exc_flags(mem_exc_flags),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_data(wb_cp0_data),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_inst_valid   = 1'b0;
    mem_exc_flags    = 5'b0;
    mem_in_delayslot = 1'b0;
    wb_cp0_we        = 1'b0;
    wb_cp0_waddr     = 5'd0;
    wb_cp0_data      = 32'h0;
    cp0_status       = 32'h0;
    cp0_cause        = 32'h0;
  endtask

  // TAKE -> BLACKOUT(3) -> IDLE takes four edges.
  task automatic recover();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic run_code(input string tag, input logic [4:0] flags, input logic [31:0] code);
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h1000;
    mem_exc_flags  = flags;
    tick();
    chk({tag, "_type"}, excepttype_o, code);
    chk({tag, "_flush"}, 32'(flush_o), 32'h1);
    chk({tag, "_newpc"}, new_pc_o, 32'h20);
    recover();
  endtask

  initial begin
    rst = 1'b1;
    mem_pc  = 32'h0;
    cp0_epc = 32'h0;
    idle_inputs();
    tick();
    tick();
    chk("rst_type", excepttype_o, 32'h0);
    chk("rst_addr", current_inst_addr_o, 32'h0);
    chk("rst_ds", 32'(is_in_delayslot_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_flush", 32'(flush_o), 32'h0);

    // Syscall, then a held syscall ignored during blackout
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h100;
    mem_exc_flags  = 5'b00001;
    tick();
    chk("sys_type", excepttype_o, 32'h8);
    chk("sys_addr", current_inst_addr_o, 32'h100);
    chk("sys_flush", 32'(flush_o), 32'h1);
    chk("sys_newpc", new_pc_o, 32'h20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bo_flush", 32'(flush_o), 32'h0);
      chk("bo_type", excepttype_o, 32'h0);
      chk("bo_addr_hold", current_inst_addr_o, 32'h100);
    end
    idle_inputs();
    tick();
    chk("post_bo_flush", 32'(flush_o), 32'h0);

    // ERET with EPC bypassed from WB
    cp0_epc        = 32'h200;
    wb_cp0_we      = 1'b1;
    wb_cp0_waddr   = 5'd14;
    wb_cp0_data    = 32'h300;
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h180;
    mem_exc_flags  = 5'b10000;
    tick();
    chk("eret_type", excepttype_o, 32'hE);
    chk("eret_newpc", new_pc_o, 32'h300);
    chk("eret_flush", 32'(flush_o), 32'h1);
    recover();

    // Interrupt arriving on bubbles, taken on the next real instruction
    cp0_status = 32'h0000FF01;
    cp0_cause  = 32'h00000400;
    tick();
    tick();
    chk("bubble_noflush", 32'(flush_o), 32'h0);
    mem_inst_valid   = 1'b1;
    mem_pc           = 32'h40;
    mem_in_delayslot = 1'b1;
    tick();
    chk("int_type", excepttype_o, 32'h1);
    chk("int_addr", current_inst_addr_o, 32'h40);
    chk("int_ds", 32'(is_in_delayslot_o), 32'h1);
    chk("int_newpc", new_pc_o, 32'h20);
    recover();

    // Priority: interrupt beats all flags, then syscall beats the rest
    cp0_status = 32'h0000FF01;
    cp0_cause  = 32'h00000400;
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h2000;
    mem_exc_flags  = 5'b01111;
    tick();
    chk("prio_int", excepttype_o, 32'h1);
    recover();
    run_code("prio_sys", 5'b01111, 32'h8);
    run_code("invalid", 5'b01110, 32'hA);
    run_code("trap", 5'b01100, 32'hD);
    run_code("ov", 5'b01000, 32'hC);

    // Software interrupt through the Cause bypass
    cp0_status     = 32'h0000FF01;
    wb_cp0_we      = 1'b1;
    wb_cp0_waddr   = 5'd13;
    wb_cp0_data    = 32'h00000100;
    mem_inst_valid = 1'b1;
    tick();
    chk("cause_byp_type", excepttype_o, 32'h1);
    recover();

    // Status.EXL set through the WB bypass suppresses a pending interrupt
    cp0_status = 32'h0000FF01;
    cp0_cause  = 32'h00000400;
    tick();
    wb_cp0_we    = 1'b1;
    wb_cp0_waddr = 5'd12;
    wb_cp0_data  = 32'h0000FF03;
    tick();
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h44;
    tick();
    chk("exl_flush0", 32'(flush_o), 32'h0);
    tick();
    chk("exl_flush1", 32'(flush_o), 32'h0);
    chk("exl_type", excepttype_o, 32'h0);
    idle_inputs();
    tick();

    // Reset during TAKE cancels the flush
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h500;
    mem_exc_flags  = 5'b00001;
    tick();
    chk("pre_rst_flush", 32'(flush_o), 32'h1);
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rst_mid_flush", 32'(flush_o), 32'h0);
    chk("rst_mid_type", excepttype_o, 32'h0);
    rst = 1'b0;
    mem_inst_valid = 1'b1;
    mem_pc         = 32'h600;
    mem_exc_flags  = 5'b00001;
    tick();
    chk("post_rst_type", excepttype_o, 32'h8);
    chk("post_rst_addr", current_inst_addr_o, 32'h600);
    chk("post_rst_flush", 32'(flush_o), 32'h1);
    idle_inputs();
    tick();
    chk("post_rst_clear", 32'(flush_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
